// File: rtl/adder_stream_arbiter.sv
// Round-robin arbiter that locks one requester onto the adder input for a full N-beat frame
// and tracks frame owners in a small FIFO so each adder result can be tagged.
module adder_stream_arbiter #(
    parameter  int NUM_REQ  = 3,
    parameter  int N        = 10,
    parameter  int WIDTH    = 8,
    parameter  int ID_DEPTH = 4,
    localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              add_s_valid,
    output logic [WIDTH-1:0]                  add_s_data,
    input  logic                              add_s_ready,
    input  logic                              add_m_valid,
    input  logic                              add_m_ready,
    output logic [IDW-1:0]                    gnt_id,
    output logic                              busy,
    output logic [IDW-1:0]                    res_id,
    output logic                              res_id_valid
);
    localparam int BCW = $clog2(N + 1);
    localparam int PW  = $clog2(ID_DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                          state, state_n;
    logic [BCW-1:0]                  beat_cnt;
    logic [IDW-1:0]                  last_gnt, arb_idx;
    logic                            arb_hit, grant, hs, push, pop, fifo_full;
    logic [ID_DEPTH-1:0][IDW-1:0]    fifo_mem;
    logic [PW-1:0]                   wr_ptr, rd_ptr, rd_ptr_n;
    logic [PW:0]                     fifo_cnt, cnt_n;
    logic [IDW-1:0]                  head_n;
    int                              cand;

    assign busy      = (state == BURST);
    assign fifo_full = (fifo_cnt == (PW+1)'(ID_DEPTH));

    // First valid requester strictly after the last winner, wrapping around.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last_gnt) + i) % NUM_REQ;
            if (!arb_hit && req_valid[cand]) begin
                arb_hit = 1'b1;
                arb_idx = IDW'(cand);
            end
        end
    end

    always_comb begin
        state_n     = state;
        req_ready   = '0;
        add_s_valid = 1'b0;
        add_s_data  = '0;
        grant       = 1'b0;
        hs          = 1'b0;
        push        = 1'b0;
        case (state)
            IDLE: begin
                if (arb_hit && !fifo_full) begin
                    grant   = 1'b1;
                    state_n = BURST;
                end
            end
            BURST: begin
                add_s_valid       = req_valid[gnt_id];
                add_s_data        = req_data[gnt_id];
                req_ready[gnt_id] = add_s_ready;
                hs                = req_valid[gnt_id] && add_s_ready;
                if (hs && beat_cnt == BCW'(N - 1)) begin
                    push    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Next-state FIFO view so res_id/res_id_valid track the head with no extra lag.
    assign pop      = add_m_valid && add_m_ready && (fifo_cnt != '0);
    assign rd_ptr_n = rd_ptr + PW'(pop);
    assign cnt_n    = fifo_cnt + (PW+1)'(push) - (PW+1)'(pop);
    assign head_n   = (push && wr_ptr == rd_ptr_n) ? gnt_id : fifo_mem[rd_ptr_n];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            last_gnt     <= IDW'(NUM_REQ - 1);
            gnt_id       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            res_id       <= '0;
            res_id_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (grant) begin
                gnt_id   <= arb_idx;
                last_gnt <= arb_idx;
            end
            if (push)
                beat_cnt <= '0;
            else if (hs)
                beat_cnt <= beat_cnt + BCW'(1);
            if (push) begin
                fifo_mem[wr_ptr] <= gnt_id;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            rd_ptr       <= rd_ptr_n;
            fifo_cnt     <= cnt_n;
            res_id_valid <= (cnt_n != '0);
            if (cnt_n != '0)
                res_id <= head_n;
        end
    end
endmodule

// File: tb/tb_adder_stream_arbiter.sv
// Directed bench for adder_stream_arbiter with NUM_REQ=3, N=4, ID_DEPTH=2.
module tb_adder_stream_arbiter;
    localparam int NUM_REQ = 3;
    localparam int N = 4;
    localparam int WIDTH = 8;
    localparam int ID_DEPTH = 2;
    localparam int IDW = 2;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          add_s_valid;
    logic [WIDTH-1:0]              add_s_data;
    logic                          add_s_ready;
    logic                          add_m_valid;
    logic                          add_m_ready;
    logic [IDW-1:0]                gnt_id;
    logic                          busy;
    logic [IDW-1:0]                res_id;
    logic                          res_id_valid;

    int checks = 0;
    int failures = 0;
    int exp_own[4] = '{0, 1, 2, 0};
    logic [WIDTH-1:0] dv[3] = '{8'hA0, 8'hB1, 8'hC2};

    always #5 clk = ~clk;

    adder_stream_arbiter #(.NUM_REQ(NUM_REQ), .N(N), .WIDTH(WIDTH), .ID_DEPTH(ID_DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .add_s_valid(add_s_valid), .add_s_data(add_s_data), .add_s_ready(add_s_ready),
        .add_m_valid(add_m_valid), .add_m_ready(add_m_ready), .gnt_id(gnt_id), .busy(busy),
        .res_id(res_id), .res_id_valid(res_id_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 0);
        chk({tag, "_svalid"}, 32'(add_s_valid), 0);
        chk({tag, "_sdata"}, 32'(add_s_data), 0);
        chk({tag, "_gnt"}, 32'(gnt_id), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_resid"}, 32'(res_id), 0);
        chk({tag, "_resvld"}, 32'(res_id_valid), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        add_s_ready = 1'b0;
        add_m_valid = 1'b0;
        add_m_ready = 1'b1;
        req_data = {dv[2], dv[1], dv[0]};
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk_reset_outputs("rst");

        // 1: only req1 requests; bubble, 4 beats, then req1 wins again
        req_valid = 3'b010; add_s_ready = 1'b1; #1;
        chk("t1_bubble_busy", 32'(busy), 0);
        chk("t1_bubble_ready", 32'(req_ready), 0);
        tick();
        chk("t1_gnt", 32'(gnt_id), 1);
        chk("t1_ready", 32'(req_ready), 32'b010);
        chk("t1_svalid", 32'(add_s_valid), 1);
        chk("t1_sdata", 32'(add_s_data), 32'(dv[1]));
        repeat (3) tick();
        chk("t1_busy_b3", 32'(busy), 1);
        tick();
        chk("t1_done_busy", 32'(busy), 0);
        chk("t1_done_ready", 32'(req_ready), 0);
        chk("t1_resvld", 32'(res_id_valid), 1);
        chk("t1_resid", 32'(res_id), 1);
        tick();
        chk("t1_regrant", 32'(gnt_id), 1);
        chk("t1_regrant_busy", 32'(busy), 1);

        // 2: all requesting with prompt result pops -> 0,1,2,0
        do_reset();
        req_valid = 3'b111; add_s_ready = 1'b1; add_m_valid = 1'b1;
        for (int f = 0; f < 4; f++) begin
            tick();
            chk("t2_gnt", 32'(gnt_id), 32'(exp_own[f]));
            chk("t2_ready", 32'(req_ready), 32'(1 << exp_own[f]));
            chk("t2_sdata", 32'(add_s_data), 32'(dv[exp_own[f]]));
            repeat (3) tick();
            chk("t2_busy_b3", 32'(busy), 1);
            tick();
            chk("t2_bubble", 32'(busy), 0);
            chk("t2_bubble_ready", 32'(req_ready), 0);
            chk("t2_resid", 32'(res_id), 32'(exp_own[f]));
            chk("t2_resvld", 32'(res_id_valid), 1);
        end

        // 3: req0 drops valid after beat 2 for 3 cycles
        do_reset();
        req_valid = 3'b111; add_s_ready = 1'b1; add_m_valid = 1'b1;
        tick();
        chk("t3_gnt", 32'(gnt_id), 0);
        tick(); tick();
        req_valid = 3'b110;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_gap_ready", 32'(req_ready), 32'b001);
            chk("t3_gap_svalid", 32'(add_s_valid), 0);
            chk("t3_gap_busy", 32'(busy), 1);
            tick();
        end
        req_valid = 3'b111;
        tick();
        chk("t3_beat3_busy", 32'(busy), 1);
        tick();
        chk("t3_end_busy", 32'(busy), 0);
        chk("t3_end_resid", 32'(res_id), 0);
        tick();
        chk("t3_next_gnt", 32'(gnt_id), 1);

        // 4: adder backpressure mid-burst on req1
        tick();
        add_s_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req_data[1] = 8'h50 + 8'(k);
            #1;
            chk("t4_sdata", 32'(add_s_data), 32'(8'h50 + 8'(k)));
            chk("t4_ready", 32'(req_ready), 0);
            chk("t4_busy", 32'(busy), 1);
            tick();
        end
        add_s_ready = 1'b1; req_data[1] = dv[1];
        tick(); tick();
        chk("t4_beat3_busy", 32'(busy), 1);
        tick();
        chk("t4_end_busy", 32'(busy), 0);
        chk("t4_end_resid", 32'(res_id), 1);

        // 5: FIFO fills with no pops, then one pop releases the arbiter a cycle later
        do_reset();
        req_valid = 3'b111; add_s_ready = 1'b1;
        repeat (10) tick();
        chk("t5_full_busy", 32'(busy), 0);
        chk("t5_full_resid", 32'(res_id), 0);
        chk("t5_full_resvld", 32'(res_id_valid), 1);
        tick(); tick();
        chk("t5_stall_busy", 32'(busy), 0);
        chk("t5_stall_ready", 32'(req_ready), 0);
        chk("t5_stall_gnt", 32'(gnt_id), 1);
        add_m_valid = 1'b1;
        tick();
        add_m_valid = 1'b0;
        chk("t5_pop_resid", 32'(res_id), 1);
        chk("t5_pop_busy", 32'(busy), 0);
        tick();
        chk("t5_regrant", 32'(gnt_id), 2);
        chk("t5_regrant_busy", 32'(busy), 1);

        // 6: reset in the middle of a burst
        tick(); tick();
        rst = 1'b1;
        tick();
        chk_reset_outputs("t6");
        rst = 1'b0;
        tick();
        chk("t6_first_gnt", 32'(gnt_id), 0);
        chk("t6_first_busy", 32'(busy), 1);
        chk("t6_fifo_empty", 32'(res_id_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
